// File: rtl/hwpe_stream_chunk_serializer_if.sv
// Handshaked stream interface: data and strobe qualified by valid/ready.
// A beat transfers on every rising edge where both valid and ready are high.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_chunk_serializer.sv
// Splits each wide stream word into NB_CHUNKS narrow beats, chunk 0 (LSBs) first.
// A one-word buffer lets the next word load as the last chunk leaves, so back-to-back words have no bubbles.
module hwpe_stream_chunk_serializer #(
  parameter int unsigned DATA_WIDTH_OUT = 8,
  parameter int unsigned NB_CHUNKS      = 2,
  parameter int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8,
  localparam int unsigned IDX_W         = (NB_CHUNKS > 1) ? $clog2(NB_CHUNKS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       idx_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                                   state_q, state_d;
  logic [IDX_W-1:0]                         cnt_q, cnt_d;
  logic [NB_CHUNKS-1:0][DATA_WIDTH_OUT-1:0] data_q, data_d;
  logic [NB_CHUNKS-1:0][STRB_WIDTH_OUT-1:0] strb_q, strb_d;

  logic                      buf_valid;
  logic                      last;
  logic                      push_ready;
  logic                      pop_valid;
  logic                      push_hs;
  logic                      pop_hs;
  logic [DATA_WIDTH_OUT-1:0] chunk_data;
  logic [STRB_WIDTH_OUT-1:0] chunk_strb;

  if (((DATA_WIDTH_OUT % 8) != 0) || (NB_CHUNKS < 1)) begin : gen_param_err
    $error("hwpe_stream_chunk_serializer: DATA_WIDTH_OUT must be a multiple of 8 and NB_CHUNKS >= 1");
  end

  // With a single chunk the counter never moves and every beat is the last one.
  if (NB_CHUNKS == 1) begin : gen_single
    assign last       = 1'b1;
    assign chunk_data = data_q[0];
    assign chunk_strb = strb_q[0];
  end else begin : gen_multi
    assign last       = (cnt_q == IDX_W'(NB_CHUNKS - 1));
    assign chunk_data = data_q[cnt_q];
    assign chunk_strb = strb_q[cnt_q];
  end

  assign buf_valid  = (state_q == HOLD);
  assign pop_valid  = buf_valid & ~clear_i;
  assign push_ready = ~clear_i & (~buf_valid | (pop_o.ready & last));
  assign push_hs    = push_i.valid & push_ready;
  assign pop_hs     = pop_valid & pop_o.ready;

  assign push_i.ready = push_ready;
  assign pop_o.valid  = pop_valid;
  assign pop_o.data   = chunk_data;
  assign pop_o.strb   = chunk_strb;
  assign busy_o       = buf_valid;
  assign idx_o        = cnt_q;

  // A push wins over the last-chunk pop, refilling the buffer in the same cycle it drains.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    strb_d  = strb_q;
    if (push_hs) begin
      data_d  = push_i.data;
      strb_d  = push_i.strb;
      state_d = HOLD;
      cnt_d   = '0;
    end else if (pop_hs) begin
      if (last) begin
        state_d = EMPTY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end
    // Clear drops the buffered word but leaves the payload registers untouched.
    if (clear_i) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_chunk_serializer.sv
// Scoreboard bench: drivers queue the chunks each wide word should produce, monitors pop and compare on every output beat.
// Covers reset, streaming, backpressure, strobe split, clear, async reset mid-word and the NB_CHUNKS=1 slice.
`timescale 1ns/1ps
module tb_hwpe_stream_chunk_serializer;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(16), .STRB_WIDTH(2)) push2 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(8),  .STRB_WIDTH(1)) pop2 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(8),  .STRB_WIDTH(1)) push1 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(8),  .STRB_WIDTH(1)) pop1 ();

  logic       busy2, busy1;
  logic [0:0] idx2, idx1;

  hwpe_stream_chunk_serializer #(.DATA_WIDTH_OUT(8), .NB_CHUNKS(2)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clear),
    .push_i (push2.sink),
    .pop_o  (pop2.source),
    .busy_o (busy2),
    .idx_o  (idx2)
  );

  hwpe_stream_chunk_serializer #(.DATA_WIDTH_OUT(8), .NB_CHUNKS(1)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clear),
    .push_i (push1.sink),
    .pop_o  (pop1.source),
    .busy_o (busy1),
    .idx_o  (idx1)
  );

  typedef struct {
    logic [7:0] data;
    logic       strb;
    logic       idx;
    int         cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  bit   contig2 = 1'b0;
  int   lastBeat2 = -1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor for the two-chunk instance.
  always @(negedge clk) begin
    if (rst_n && pop2.valid && pop2.ready) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut2 unexpected beat: got data 0x%0h, expected no beat", pop2.data);
      end else begin
        exp_t e;
        e = q2.pop_front();
        checkOutput("dut2 data", 32'(pop2.data), 32'(e.data));
        checkOutput("dut2 strb", 32'(pop2.strb), 32'(e.strb));
        checkOutput("dut2 idx",  32'(idx2),      32'(e.idx));
        if (e.cyc >= 0) checkOutput("dut2 beat cycle", 32'(cycle), 32'(e.cyc));
      end
      if (contig2) begin
        if (lastBeat2 >= 0) checkOutput("dut2 stream gap", 32'(cycle), 32'(lastBeat2 + 1));
        lastBeat2 = cycle;
      end
    end
    if (contig2 && rst_n)
      checkOutput("dut2 push ready rule", 32'(push2.ready), 32'(!busy2 || (idx2 == 1'b1)));
  end

  // Monitor for the single-chunk instance.
  always @(negedge clk) begin
    if (rst_n && pop1.valid && pop1.ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut1 unexpected beat: got data 0x%0h, expected no beat", pop1.data);
      end else begin
        exp_t e;
        e = q1.pop_front();
        checkOutput("dut1 data",       32'(pop1.data), 32'(e.data));
        checkOutput("dut1 strb",       32'(pop1.strb), 32'(e.strb));
        checkOutput("dut1 idx",        32'(idx1),      32'(e.idx));
        checkOutput("dut1 beat cycle", 32'(cycle),     32'(e.cyc));
      end
    end
  end

  // Offers one wide word; on acceptance queues the first nEnq chunks it should produce.
  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] s, input int nEnq, input bit timed);
    bit hs = 1'b0;
    int n = 0;
    push2.valid = 1'b1;
    push2.data  = d;
    push2.strb  = s;
    while (!hs && n < 100) begin
      @(negedge clk);
      if (push2.ready) begin
        hs = 1'b1;
        for (int k = 0; k < nEnq; k++) begin
          exp_t e;
          e.data = d[k*8 +: 8];
          e.strb = s[k];
          e.idx  = k[0];
          e.cyc  = timed ? cycle + 1 + k : -1;
          q2.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut2 push timeout: got no handshake, expected one within 100 cycles");
    end
    push2.valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] words1[5];
    words1 = '{8'h5A, 8'h5A, 8'hA5, 8'h3C, 8'h5A};

    rst_n       = 1'b0;
    clear       = 1'b0;
    push2.valid = 1'b0;
    push2.data  = '0;
    push2.strb  = '0;
    pop2.ready  = 1'b1;
    push1.valid = 1'b0;
    push1.data  = '0;
    push1.strb  = 1'b1;
    pop1.ready  = 1'b1;

    // Reset values
    #2;
    checkOutput("reset pop valid",  32'(pop2.valid),  32'h0);
    checkOutput("reset pop data",   32'(pop2.data),   32'h0);
    checkOutput("reset pop strb",   32'(pop2.strb),   32'h0);
    checkOutput("reset busy",       32'(busy2),       32'h0);
    checkOutput("reset idx",        32'(idx2),        32'h0);
    checkOutput("reset push ready", 32'(push2.ready), 32'h1);
    #20 rst_n = 1'b1;
    waitCycles(1);

    // Single word, chunk 0 then chunk 1, idle afterwards
    applyStimulus(16'hBBAA, 2'b11, 2, 1'b1);
    waitCycles(2);
    @(negedge clk);
    checkOutput("single busy after", 32'(busy2),      32'h0);
    checkOutput("single valid after", 32'(pop2.valid), 32'h0);
    waitCycles(1);

    // Back-to-back streaming with ready held high
    contig2   = 1'b1;
    lastBeat2 = -1;
    applyStimulus(16'h1100, 2'b11, 2, 1'b1);
    applyStimulus(16'h3322, 2'b11, 2, 1'b1);
    applyStimulus(16'h5544, 2'b11, 2, 1'b1);
    waitCycles(2);
    contig2 = 1'b0;
    checkOutput("stream beat count", 32'(q2.size()), 32'h0);

    // Backpressure: first chunk held stable for three cycles
    pop2.ready = 1'b0;
    applyStimulus(16'hBBAA, 2'b11, 2, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp valid",      32'(pop2.valid),  32'h1);
      checkOutput("bp data",       32'(pop2.data),   32'hAA);
      checkOutput("bp idx",        32'(idx2),        32'h0);
      checkOutput("bp push ready", 32'(push2.ready), 32'h0);
      @(posedge clk);
      #1;
    end
    pop2.ready = 1'b1;
    waitCycles(3);

    // All-zero strobe chunk is still emitted
    applyStimulus(16'hBBAA, 2'b10, 2, 1'b1);
    waitCycles(3);

    // Clear after chunk 0 leaves; a push offered during clear must be ignored
    applyStimulus(16'h2211, 2'b11, 1, 1'b1);
    waitCycles(1);
    clear       = 1'b1;
    push2.valid = 1'b1;
    push2.data  = 16'hFFEE;
    @(negedge clk);
    checkOutput("clear pop valid",  32'(pop2.valid),  32'h0);
    checkOutput("clear push ready", 32'(push2.ready), 32'h0);
    @(posedge clk);
    #1;
    clear       = 1'b0;
    push2.valid = 1'b0;
    @(negedge clk);
    checkOutput("post clear busy",  32'(busy2),      32'h0);
    checkOutput("post clear idx",   32'(idx2),       32'h0);
    checkOutput("post clear valid", 32'(pop2.valid), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(16'hDDCC, 2'b11, 2, 1'b1);
    waitCycles(3);

    // Asynchronous reset while a word is held
    pop2.ready = 1'b0;
    applyStimulus(16'h4433, 2'b11, 0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst pop valid",  32'(pop2.valid),  32'h0);
    checkOutput("async rst pop data",   32'(pop2.data),   32'h0);
    checkOutput("async rst pop strb",   32'(pop2.strb),   32'h0);
    checkOutput("async rst busy",       32'(busy2),       32'h0);
    checkOutput("async rst idx",        32'(idx2),        32'h0);
    checkOutput("async rst push ready", 32'(push2.ready), 32'h1);
    #4;
    rst_n      = 1'b1;
    pop2.ready = 1'b1;
    waitCycles(1);
    @(negedge clk);
    checkOutput("after rst busy",  32'(busy2),      32'h0);
    checkOutput("after rst valid", 32'(pop2.valid), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(16'h6655, 2'b01, 2, 1'b1);
    waitCycles(3);

    // Single-chunk slice: one beat per cycle at latency 1
    foreach (words1[i]) begin
      exp_t e;
      push1.valid = 1'b1;
      push1.data  = words1[i];
      @(negedge clk);
      checkOutput("dut1 push ready", 32'(push1.ready), 32'h1);
      e.data = words1[i];
      e.strb = 1'b1;
      e.idx  = 1'b0;
      e.cyc  = cycle + 1;
      q1.push_back(e);
      @(posedge clk);
      #1;
    end
    push1.valid = 1'b0;
    waitCycles(3);

    checkOutput("dut2 queue drained", 32'(q2.size()), 32'h0);
    checkOutput("dut1 queue drained", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
